// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one d_cache request at a time, stalls execute
// until the response (or a timeout), then hands a registered result to writeback.
package nand_cpu_pkg;
    typedef enum logic {LOAD = 1'b0, STORE = 1'b1} MemOp;
endpackage

module mem_stage #(
    parameter int REG_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                ex_valid,
    input  logic                ex_mem_access,
    input  nand_cpu_pkg::MemOp  ex_mem_op,
    input  logic [15:0]         ex_address,
    input  logic [15:0]         ex_data,
    input  logic [REG_W-1:0]    ex_dest,
    input  logic                ex_wb_en,
    input  logic                flush,
    output logic                stall,
    output logic                dc_valid,
    output logic                dc_mem_access,
    output logic [15:0]         dc_address,
    output nand_cpu_pkg::MemOp  dc_mem_op,
    output logic [15:0]         dc_data,
    input  logic                dc_resp_valid,
    input  logic [15:0]         dc_resp_data,
    output logic                wb_valid,
    output logic                wb_en,
    output logic [REG_W-1:0]    wb_dest,
    output logic [15:0]         wb_data,
    output logic                mem_fault
);
    import nand_cpu_pkg::*;

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    // Writeback side of the outstanding request; the cache side lives in dc_*.
    typedef struct packed {
        logic [REG_W-1:0] dest;
        logic             wb_en;
    } req_t;

    state_t           state;
    req_t             req;
    logic [CNT_W-1:0] cnt;
    logic             kill;

    // Released in the response cycle so execute can present the next op to IDLE.
    assign stall = (state == WAIT) && !dc_resp_valid;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state         <= IDLE;
            req           <= '0;
            cnt           <= '0;
            kill          <= 1'b0;
            dc_valid      <= 1'b0;
            dc_mem_access <= 1'b0;
            dc_address    <= '0;
            dc_mem_op     <= LOAD;
            dc_data       <= '0;
            wb_valid      <= 1'b0;
            wb_en         <= 1'b0;
            wb_dest       <= '0;
            wb_data       <= '0;
            mem_fault     <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_en    <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid && !flush) begin
                        if (!ex_mem_access) begin
                            wb_valid <= 1'b1;
                            wb_en    <= ex_wb_en;
                            wb_dest  <= ex_dest;
                            wb_data  <= ex_data;
                        end else begin
                            dc_valid      <= 1'b1;
                            dc_mem_access <= 1'b1;
                            dc_address    <= ex_address;
                            dc_mem_op     <= ex_mem_op;
                            dc_data       <= ex_data;
                            req.dest      <= ex_dest;
                            req.wb_en     <= ex_wb_en;
                            cnt           <= '0;
                            kill          <= 1'b0;
                            state         <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dc_resp_valid) begin
                        state    <= IDLE;
                        dc_valid <= 1'b0;
                        kill     <= 1'b0;
                        // A flush arriving with the response still squashes the result.
                        if (!(kill || flush)) begin
                            wb_valid <= 1'b1;
                            wb_dest  <= req.dest;
                            if (dc_mem_op == LOAD) begin
                                wb_data <= dc_resp_data;
                                wb_en   <= req.wb_en;
                            end else begin
                                wb_data <= '0;
                            end
                        end
                    end else if (cnt == CNT_MAX) begin
                        state     <= IDLE;
                        dc_valid  <= 1'b0;
                        kill      <= 1'b0;
                        mem_fault <= 1'b1;
                    end else begin
                        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
                        // The request keeps going so a store still commits.
                        if (flush) kill <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Transaction-level randomized bench for mem_stage: each instruction's outcome
// is predicted from its response delay and flush timing.
module tb_mem_stage;
    import nand_cpu_pkg::*;

    localparam int REG_W   = 4;
    localparam int TIMEOUT = 4;

    logic              clk = 1'b0;
    logic              n_rst;
    logic              ex_valid, ex_mem_access, ex_wb_en, flush;
    MemOp              ex_mem_op;
    logic [15:0]       ex_address, ex_data;
    logic [REG_W-1:0]  ex_dest;
    logic              stall, dc_valid, dc_mem_access;
    logic [15:0]       dc_address, dc_data;
    MemOp              dc_mem_op;
    logic              dc_resp_valid;
    logic [15:0]       dc_resp_data;
    logic              wb_valid, wb_en, mem_fault;
    logic [REG_W-1:0]  wb_dest;
    logic [15:0]       wb_data;

    int n_cmp = 0;
    int n_err = 0;
    bit fault_exp = 1'b0;

    mem_stage #(.REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .n_rst(n_rst),
        .ex_valid(ex_valid), .ex_mem_access(ex_mem_access), .ex_mem_op(ex_mem_op),
        .ex_address(ex_address), .ex_data(ex_data), .ex_dest(ex_dest), .ex_wb_en(ex_wb_en),
        .flush(flush), .stall(stall),
        .dc_valid(dc_valid), .dc_mem_access(dc_mem_access), .dc_address(dc_address),
        .dc_mem_op(dc_mem_op), .dc_data(dc_data),
        .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
        .wb_valid(wb_valid), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_mem_access = 1'b0; ex_mem_op = LOAD; ex_address = '0;
        ex_data = '0; ex_dest = '0; ex_wb_en = 1'b0; flush = 1'b0;
        dc_resp_valid = 1'b0; dc_resp_data = '0;
    endtask

    // Non-memory op, optionally squashed by a same-cycle flush; a stray
    // response in IDLE must be ignored.
    task automatic run_alu(input logic [15:0] d, input logic [REG_W-1:0] dst,
                           input bit we, input bit fl);
        ex_valid = 1'b1; ex_mem_access = 1'b0; ex_data = d; ex_dest = dst;
        ex_wb_en = we; flush = fl; ex_mem_op = MemOp'($urandom_range(0, 1));
        dc_resp_valid = 1'($urandom_range(0, 1)); dc_resp_data = 16'($urandom);
        #1 chk("alu_stall", stall, 0);
        tick();
        idle_inputs();
        chk("alu_wb_valid", wb_valid, !fl);
        chk("alu_wb_en", wb_en, !fl && we);
        if (!fl) begin
            chk("alu_wb_data", wb_data, d);
            chk("alu_wb_dest", wb_dest, dst);
        end
        chk("alu_dc_valid", dc_valid, 0);
        chk("alu_fault", mem_fault, fault_exp);
    endtask

    // Memory op answered in WAIT cycle `dly` (> TIMEOUT means never) with a
    // flush in WAIT cycle `fl_at` (out of range means none).
    task automatic run_mem(input MemOp op, input logic [15:0] addr, input logic [15:0] d,
                           input logic [REG_W-1:0] dst, input bit we,
                           input int dly, input int fl_at);
        logic [15:0] rdata = '0;
        bit done = 1'b0;
        bit completes = (dly <= TIMEOUT);
        bit killed = (fl_at <= dly) && (fl_at <= TIMEOUT);
        bit wbv = completes && !killed;
        ex_valid = 1'b1; ex_mem_access = 1'b1; ex_mem_op = op; ex_address = addr;
        ex_data = d; ex_dest = dst; ex_wb_en = we; flush = 1'b0;
        #1 chk("mem_accept_stall", stall, 0);
        tick();
        for (int k = 0; !done; k++) begin
            chk("wait_dc_valid", dc_valid, 1);
            chk("wait_dc_access", dc_mem_access, 1);
            chk("wait_dc_addr", dc_address, addr);
            chk("wait_dc_data", dc_data, d);
            chk("wait_dc_op", 32'(dc_mem_op), 32'(op));
            chk("wait_wb_valid", wb_valid, 0);
            // Upstream junk while stalled must not be picked up.
            ex_valid = 1'($urandom_range(0, 1)); ex_mem_access = 1'($urandom_range(0, 1));
            ex_address = 16'($urandom); ex_data = 16'($urandom);
            dc_resp_valid = (k == dly);
            dc_resp_data = 16'($urandom);
            if (k == dly) rdata = dc_resp_data;
            flush = (k == fl_at);
            #1 chk("wait_stall", stall, k != dly);
            done = (k == dly) || (k == TIMEOUT);
            tick();
        end
        idle_inputs();
        if (!completes) fault_exp = 1'b1;
        chk("done_dc_valid", dc_valid, 0);
        chk("done_stall", stall, 0);
        chk("done_wb_valid", wb_valid, wbv);
        chk("done_wb_en", wb_en, wbv && op == LOAD && we);
        if (wbv) begin
            chk("done_wb_data", wb_data, (op == LOAD) ? rdata : 16'h0);
            chk("done_wb_dest", wb_dest, dst);
        end
        chk("done_fault", mem_fault, fault_exp);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dc_valid"}, dc_valid, 0);
        chk({tag, "_dc_access"}, dc_mem_access, 0);
        chk({tag, "_dc_addr"}, dc_address, 0);
        chk({tag, "_dc_op"}, 32'(dc_mem_op), 0);
        chk({tag, "_dc_data"}, dc_data, 0);
        chk({tag, "_wb_valid"}, wb_valid, 0);
        chk({tag, "_wb_en"}, wb_en, 0);
        chk({tag, "_wb_dest"}, wb_dest, 0);
        chk({tag, "_wb_data"}, wb_data, 0);
        chk({tag, "_fault"}, mem_fault, 0);
        chk({tag, "_stall"}, stall, 0);
    endtask

    initial begin
        idle_inputs();
        n_rst = 1'b0;
        @(negedge clk);
        tick();
        chk_all_zero("rst");
        n_rst = 1'b1;
        tick();

        // Directed cases
        run_alu(16'h1234, 4'd3, 1'b1, 1'b0);
        run_mem(LOAD, 16'h0040, 16'h0000, 4'd5, 1'b1, 3, 99);
        run_mem(STORE, 16'hFFFE, 16'h00AA, 4'd6, 1'b1, 1, 99);
        run_mem(LOAD, 16'h0100, 16'h0000, 4'd7, 1'b1, 2, 1);
        run_alu(16'h5555, 4'd2, 1'b1, 1'b0);
        run_mem(LOAD, 16'h0200, 16'h0000, 4'd8, 1'b1, TIMEOUT, TIMEOUT);
        run_mem(LOAD, 16'h0202, 16'h0000, 4'd9, 1'b1, 0, 99);
        run_mem(STORE, 16'h0300, 16'h1111, 4'd1, 1'b0, TIMEOUT, 99);
        run_alu(16'hDEAD, 4'd4, 1'b1, 1'b1);
        run_mem(LOAD, 16'h0400, 16'h0000, 4'd2, 1'b1, 99, 99);
        run_alu(16'h0F0F, 4'd11, 1'b0, 1'b0);

        // Randomized mix
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0)
                run_alu(16'($urandom), REG_W'($urandom), 1'($urandom_range(0, 1)),
                        ($urandom_range(0, 4) == 0));
            else
                run_mem(MemOp'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                        REG_W'($urandom), 1'($urandom_range(0, 1)),
                        $urandom_range(0, TIMEOUT + 2), $urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) begin
                dc_resp_valid = 1'b1; dc_resp_data = 16'($urandom);
                ex_valid = 1'($urandom_range(0, 1)); ex_mem_access = 1'b1; flush = 1'b1;
                tick();
                idle_inputs();
                chk("gap_dc_valid", dc_valid, 0);
                chk("gap_wb_valid", wb_valid, 0);
            end
        end

        // Reset in the middle of a request, stale response afterwards
        ex_valid = 1'b1; ex_mem_access = 1'b1; ex_mem_op = STORE;
        ex_address = 16'hABCD; ex_data = 16'h4321; ex_dest = 4'd9; ex_wb_en = 1'b1;
        tick();
        idle_inputs();
        tick();
        chk("pre_rst_dc_valid", dc_valid, 1);
        n_rst = 1'b0;
        dc_resp_valid = 1'b1; dc_resp_data = 16'hBEEF;
        tick();
        n_rst = 1'b1;
        chk_all_zero("midrst");
        tick();
        chk_all_zero("stale");
        dc_resp_valid = 1'b0;
        fault_exp = 1'b0;
        run_alu(16'h00C3, 4'd1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
